// File: rtl/load_store_unit_if.sv
// load_store_unit_if: request/response and data-memory bus for the load/store unit.
//   req_*   : pipeline request (valid/ready handshake, store flag, size, extend mode, addr, data)
//   resp_*  : one-cycle completion pulse with load data and error flag
//   mem_*   : single-port word-wide data memory (adr, wdata, w, r, rdata)
// Modports:
//   slave  : the load/store unit itself
//   master : the pipeline plus memory on the other side (bench / integration)
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_adr;
  logic [31:0] mem_wdata;
  logic        mem_w;
  logic        mem_r;
  logic [31:0] mem_rdata;

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err, mem_adr, mem_wdata, mem_w, mem_r
  );

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err, mem_adr, mem_wdata, mem_w, mem_r
  );
endinterface

// File: rtl/load_store_unit.sv
// load_store_unit: memory-stage initiator for a single-port word-wide data memory.
//   Takes one load/store at a time, performs word reads/writes, extracts and extends
//   byte/half/word loads, and does read-modify-write for byte/half stores.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   lsu  : load_store_unit_if.slave (request, response and memory bus)
// Parameters:
//   MEM_DEPTH    : words behind the memory port
//   MEM_ADR_WORD : 1 -> mem_adr is a word index, 0 -> mem_adr is a word-aligned byte address
// Optional feature:
//   LSU_BOUNDS_CHECK_EN : when defined, addresses >= MEM_DEPTH*4 complete with an error and no
//   memory access; otherwise the word index wraps modulo MEM_DEPTH.
module load_store_unit #(
  parameter int unsigned MEM_DEPTH    = 16,
  parameter int unsigned MEM_ADR_WORD = 1
) (
  input logic             clk,
  input logic             rst,
  load_store_unit_if.slave lsu
);

  typedef enum logic [2:0] {StIdle, StRd, StCap, StWr, StResp} state_e;

  state_e      state_q, state_d;
  logic        we_q;
  logic [1:0]  size_q;
  logic        unsigned_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        err_q;
  logic [31:0] word_q;
  logic [31:0] rdata_q;

  logic        req_err;
  logic        rd_en, wr_en, ready, resp_valid;
  logic [29:0] widx;
  logic [31:0] ld_data;
  logic [31:0] merged;
  logic [7:0]  lane8;
  logic [15:0] lane16;

  // Alignment / size (and optionally range) check on the incoming request.
  always_comb begin
    req_err = 1'b0;
    case (lsu.req_size)
      2'b00:   req_err = 1'b0;
      2'b01:   req_err = lsu.req_addr[0];
      2'b10:   req_err = |lsu.req_addr[1:0];
      default: req_err = 1'b1;
    endcase
`ifdef LSU_BOUNDS_CHECK_EN
    if (lsu.req_addr >= 32'(MEM_DEPTH * 4)) req_err = 1'b1;
`endif
  end

  always_comb begin
    state_d    = state_q;
    ready      = 1'b0;
    resp_valid = 1'b0;
    rd_en      = 1'b0;
    wr_en      = 1'b0;
    case (state_q)
      StIdle: begin
        ready = 1'b1;
        if (lsu.req_valid) begin
          if (req_err) begin
            state_d = StResp;
          end else if (lsu.req_we && (lsu.req_size == 2'b10)) begin
            state_d = StWr;
          end else begin
            state_d = StRd;
          end
        end
      end
      StRd: begin
        rd_en   = 1'b1;
        state_d = StCap;
      end
      StCap: begin
        // Read data is valid in this second read cycle.
        rd_en   = 1'b1;
        state_d = we_q ? StWr : StResp;
      end
      StWr: begin
        wr_en   = 1'b1;
        state_d = StResp;
      end
      StResp: begin
        resp_valid = 1'b1;
        state_d    = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Word index wraps modulo the memory depth; the modulo also keeps every address bit in use.
  assign widx = addr_q[31:2] % 30'(MEM_DEPTH);

  always_comb begin
    lsu.mem_adr = 32'h0;
    if (rd_en || wr_en) begin
      if (MEM_ADR_WORD != 0) lsu.mem_adr = {2'b00, widx};
      else                   lsu.mem_adr = {widx, 2'b00};
    end
  end

  // Load extraction, little-endian lanes.
  always_comb begin
    lane8  = lsu.mem_rdata[{addr_q[1:0], 3'b000} +: 8];
    lane16 = addr_q[1] ? lsu.mem_rdata[31:16] : lsu.mem_rdata[15:0];
    case (size_q)
      2'b00:   ld_data = unsigned_q ? {24'h0, lane8} : {{24{lane8[7]}}, lane8};
      2'b01:   ld_data = unsigned_q ? {16'h0, lane16} : {{16{lane16[15]}}, lane16};
      default: ld_data = lsu.mem_rdata;
    endcase
  end

  // Sub-word store: replace the addressed lane(s) in the word captured during StCap.
  always_comb begin
    merged = word_q;
    if (size_q == 2'b00) begin
      merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
    end else if (size_q == 2'b01) begin
      merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
    end
  end

  assign lsu.mem_wdata  = wr_en ? ((size_q == 2'b10) ? wdata_q : merged) : 32'h0;
  assign lsu.mem_r      = rd_en;
  assign lsu.mem_w      = wr_en;
  assign lsu.req_ready  = ready;
  assign lsu.resp_valid = resp_valid;
  assign lsu.resp_err   = resp_valid & err_q;
  assign lsu.resp_rdata = rdata_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      we_q       <= 1'b0;
      size_q     <= 2'b00;
      unsigned_q <= 1'b0;
      addr_q     <= 32'h0;
      wdata_q    <= 32'h0;
      err_q      <= 1'b0;
      word_q     <= 32'h0;
      rdata_q    <= 32'h0;
    end else begin
      state_q <= state_d;
      if (state_q == StIdle && lsu.req_valid) begin
        we_q       <= lsu.req_we;
        size_q     <= lsu.req_size;
        unsigned_q <= lsu.req_unsigned;
        addr_q     <= lsu.req_addr;
        wdata_q    <= lsu.req_wdata;
        err_q      <= req_err;
      end
      if (state_q == StCap) word_q <= lsu.mem_rdata;
      // resp_rdata only changes on entry to StResp so it holds between responses.
      if (state_d == StResp && state_q != StResp) begin
        rdata_q <= (state_q == StCap && !we_q) ? ld_data : 32'h0;
      end
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          lat;
    int          acc;
  } resp_t;

  typedef struct {
    logic [31:0] adr;
    logic [31:0] data;
  } wr_t;

  logic clk  = 1'b0;
  logic rst  = 1'b1;
  logic init = 1'b1;
  int   cyc  = 0;
  int   checks = 0;
  int   errors = 0;
  int   rd_cnt = 0;

  resp_t rq[$];
  wr_t   wq[$];
  logic [31:0] mem [16];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  load_store_unit_if bus ();

  load_store_unit #(
    .MEM_DEPTH   (16),
    .MEM_ADR_WORD(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .lsu(bus)
  );

  // Memory model: commits writes on the edge, read data registered one cycle after mem_r.
  always @(posedge clk) begin
    if (init) begin
      for (int i = 0; i < 16; i++) mem[i] <= 32'h1000_0000 + 32'(i);
    end else begin
      if (bus.mem_w) mem[bus.mem_adr[3:0]] <= bus.mem_wdata;
      if (bus.mem_r) bus.mem_rdata <= mem[bus.mem_adr[3:0]];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor / scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.resp_valid) begin
        if (rq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_resp: got resp_valid 1, expected 0");
        end else begin
          resp_t r;
          r = rq.pop_front();
          chk("resp_err", 32'(bus.resp_err), 32'(r.err));
          chk("resp_rdata", bus.resp_rdata, r.rdata);
          chk("resp_latency", 32'(cyc - r.acc), 32'(r.lat));
        end
      end
      if (bus.mem_w) begin
        if (wq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: got mem_w 1 adr %h, expected 0", bus.mem_adr);
        end else begin
          wr_t w;
          w = wq.pop_front();
          chk("mem_adr_wr", bus.mem_adr, w.adr);
          chk("mem_wdata", bus.mem_wdata, w.data);
        end
      end
      if (bus.mem_r) rd_cnt++;
      if (bus.mem_r || bus.mem_w) chk("rw_exclusive", 32'(bus.mem_r & bus.mem_w), 32'h0);
      if (bus.req_ready || bus.resp_valid) chk("adr_zero_idle", bus.mem_adr, 32'h0);
    end
  end

  task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic eerr, input logic [31:0] erd, input int lat);
    resp_t r;
    int    n;
    n = 0;
    @(negedge clk);
    while (!bus.req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!bus.req_ready) begin
      chk("ready_timeout", 32'(bus.req_ready), 32'h1);
      return;
    end
    bus.req_valid    = 1'b1;
    bus.req_we       = we;
    bus.req_size     = size;
    bus.req_unsigned = uns;
    bus.req_addr     = addr;
    bus.req_wdata    = wdata;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    bus.req_addr  = 32'hFFFF_FFFF;
    bus.req_wdata = 32'hFFFF_FFFF;
    r.err   = eerr;
    r.rdata = erd;
    r.lat   = lat;
    r.acc   = cyc - 1;
    rq.push_back(r);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.req_ready && n < 20);
    if (!bus.req_ready) chk("done_timeout", 32'(bus.req_ready), 32'h1);
  endtask

  task automatic push_wr(input logic [31:0] adr, input logic [31:0] data);
    wr_t w;
    w.adr  = adr;
    w.data = data;
    wq.push_back(w);
  endtask

  initial begin
    int rd0;
    bus.req_valid    = 1'b0;
    bus.req_we       = 1'b0;
    bus.req_size     = 2'b00;
    bus.req_unsigned = 1'b0;
    bus.req_addr     = 32'h0;
    bus.req_wdata    = 32'h0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", 32'(bus.req_ready), 32'h1);
    chk("rst_resp_valid", 32'(bus.resp_valid), 32'h0);
    chk("rst_resp_err", 32'(bus.resp_err), 32'h0);
    chk("rst_resp_rdata", bus.resp_rdata, 32'h0);
    chk("rst_mem_rw", {30'h0, bus.mem_r, bus.mem_w}, 32'h0);
    chk("rst_mem_adr", bus.mem_adr, 32'h0);
    chk("rst_mem_wdata", bus.mem_wdata, 32'h0);
    init = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // sw, then loads of word 1
    push_wr(32'h1, 32'h8899_AABB);
    issue(1'b1, 2'b10, 1'b0, 32'h4, 32'h8899_AABB, 1'b0, 32'h0, 2);
    issue(1'b0, 2'b00, 1'b0, 32'h5, 32'h0, 1'b0, 32'hFFFF_FFAA, 3);
    issue(1'b0, 2'b00, 1'b1, 32'h5, 32'h0, 1'b0, 32'h0000_00AA, 3);
    issue(1'b0, 2'b01, 1'b1, 32'h6, 32'h0, 1'b0, 32'h0000_8899, 3);
    issue(1'b0, 2'b01, 1'b0, 32'h6, 32'h0, 1'b0, 32'hFFFF_8899, 3);
    issue(1'b0, 2'b10, 1'b0, 32'h4, 32'h0, 1'b0, 32'h8899_AABB, 3);

    // sub-word stores: read-modify-write
    push_wr(32'h1, 32'h1199_AABB);
    issue(1'b1, 2'b00, 1'b0, 32'h7, 32'hFFFF_FF11, 1'b0, 32'h0, 4);
    issue(1'b0, 2'b10, 1'b0, 32'h4, 32'h0, 1'b0, 32'h1199_AABB, 3);
    push_wr(32'h0, 32'hCAFE_0000);
    issue(1'b1, 2'b01, 1'b0, 32'h2, 32'hDEAD_CAFE, 1'b0, 32'h0, 4);
    issue(1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 1'b0, 32'hCAFE_0000, 3);

    // errors: no memory access, response one cycle after accept
    rd0 = rd_cnt;
    issue(1'b0, 2'b01, 1'b0, 32'h3, 32'h0, 1'b1, 32'h0, 1);
    issue(1'b0, 2'b10, 1'b0, 32'h6, 32'h0, 1'b1, 32'h0, 1);
    issue(1'b0, 2'b11, 1'b0, 32'h0, 32'h0, 1'b1, 32'h0, 1);
    issue(1'b1, 2'b10, 1'b0, 32'h2, 32'h1234_5678, 1'b1, 32'h0, 1);
    chk("err_no_read", 32'(rd_cnt), 32'(rd0));

    // reset during CAP of a byte store
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_size  = 2'b00;
    bus.req_addr  = 32'h8;
    bus.req_wdata = 32'h55;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    @(posedge clk);
    #2;
    chk("t5_in_cap", 32'(bus.mem_r), 32'h1);
    rst = 1'b1;
    #1;
    chk("t5_rst_resp_valid", 32'(bus.resp_valid), 32'h0);
    chk("t5_rst_mem_rw", {30'h0, bus.mem_r, bus.mem_w}, 32'h0);
    chk("t5_rst_mem_adr", bus.mem_adr, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("t5_ready_after", 32'(bus.req_ready), 32'h1);
    issue(1'b0, 2'b10, 1'b0, 32'h8, 32'h0, 1'b0, 32'h1000_0002, 3);

    // out-of-range word load
`ifdef LSU_BOUNDS_CHECK_EN
    rd0 = rd_cnt;
    issue(1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 1'b1, 32'h0, 1);
    chk("oob_no_read", 32'(rd_cnt), 32'(rd0));
`else
    issue(1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 1'b0, 32'hCAFE_0000, 3);
    issue(1'b0, 2'b00, 1'b1, 32'h45, 32'h0, 1'b0, 32'h0000_00AA, 3);
`endif

    repeat (4) @(negedge clk);
    chk("resp_queue_empty", 32'(rq.size()), 32'h0);
    chk("write_queue_empty", 32'(wq.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
